ttc_chanb_broadcast_tx: RTL
===========================

// Module: ttc_chanb_broadcast_tx
// PURPOSE
//  Transmit side of TTC Channel B. Turns local requests (fill type, trigger timestamp reset,
//  event count reset) into 8-bit broadcast commands for the TTC encoder, one command per handshake.
//  Commands are byte-compatible with the Channel B receiver: Brcst[7:2]=info, [1]=BCntRes=0, [0]=EvCntRes.
//  Per-kind pending latches, fixed priority, event-count-reset merged, enforced inter-command gap.
// PARAMETERS
//  MIN_GAP    44  idle clk cycles forced after each accepted command (0 = no gap)
//  CNT_WIDTH  16  width of status counters
// PORTS
//  clk              in   1          system clock
//  reset            in   1          synchronous, active-high
//  tx_enable        in   1          1 = new commands may be launched
//  req_fill_type    in   1          1-cycle request: broadcast fill type
//  fill_type_in     in   2          fill type sampled with req_fill_type
//  req_ts_reset     in   1          1-cycle request: trigger timestamp reset
//  req_evt_reset    in   1          1-cycle request: event count reset
//  brcst_data       out  8          command byte to TTC encoder
//  brcst_valid      out  1          command valid
//  brcst_ready      in   1          encoder accepts when valid & ready at posedge
//  busy             out  1          FSM not in IDLE
//  pending          out  3          {evt, ts, fill} pending flags
//  sent_count       out  CNT_WIDTH  commands accepted by encoder, wraps
//  coalesced_count  out  CNT_WIDTH  requests merged into an already-pending one, saturates
//  rejected_count   out  CNT_WIDTH  fill requests with fill_type_in==2'b00, saturates
// BEHAVIOUR
//  Reset: all outputs, pending flags, counters = 0; FSM=IDLE; stored fill type = 2'b01.
//   Reset mid-transfer drops the command: brcst_valid = 0 after the reset edge; no count.
//  Request capture, every cycle including during reset release:
//   req_fill_type with fill_type_in!=0 -> fill pending, stored fill type = fill_type_in (latest wins).
//   req_fill_type with fill_type_in==0 -> ignored, rejected_count++.
//   Request of a kind already pending (before this edge) -> coalesced_count++, stays one command.
//   A set in the same cycle as that kind's load-clear wins: a second command follows.
//  Encoding (e = evt pending at load):
//   fill: {1'b1, ft[1:0], 3'b000, 1'b0, e}
//   ts:   8'b0010_100e
//   evt only: 8'b0000_0001
//  Priority at load: ts > fill > evt-only. evt pending merges into whichever is loaded;
//   loaded kind(s) cleared at the load edge.
//  FSM:
//   IDLE -> SEND when tx_enable & |pending; brcst_data loaded, brcst_valid=1 same edge.
//    Latency: request in cycle k -> brcst_valid high from edge k+2.
//   SEND: valid and data held stable until valid&ready at a posedge; then sent_count++
//    and valid=0. Go to GAP when MIN_GAP>0, else IDLE.
//    tx_enable low does not abort SEND.
//   GAP: counts MIN_GAP cycles (valid=0), then IDLE. Requests keep latching.
//  Counters: sent_count wraps modulo 2^CNT_WIDTH; coalesced/rejected hold at all-ones.
// TESTING
//  1 req_fill_type, ft=2'b10, ready=1 -> brcst_data=8'hC0 valid 1 cycle at k+2; sent_count=1;
//    next command no earlier than 44 cycles later.
//  2 req_ts_reset + req_evt_reset same cycle -> single 8'h29; pending returns to 0.
//  3 req_fill_type ft=01 + req_ts_reset same cycle -> 8'h28 first, then 8'hA0 after gap.
//  4 ready=0 for 10 cycles -> valid/data stable 10 cycles; accepted on 1st ready; count once.
//  5 fill ft=11 twice during GAP, then ft=00 -> one 8'hE0; coalesced=1; rejected=1.
//  6 reset in SEND; separately tx_enable=0 with 3 requests -> valid low, counters 0;
//    requests held; enable=1 -> 3 commands in priority order.

Source files
------------

// File: rtl/ttc_chanb_broadcast_tx_if.sv
// Broadcast command channel toward the TTC encoder: byte plus valid/ready handshake.
interface ttc_chanb_broadcast_tx_if;
    logic [7:0] brcst_data;
    logic       brcst_valid;
    logic       brcst_ready;

    modport master (output brcst_data, output brcst_valid, input brcst_ready);
    modport slave  (input brcst_data, input brcst_valid, output brcst_ready);
endinterface

// File: rtl/ttc_chanb_broadcast_tx.sv
// TTC Channel B broadcast transmitter: latched requests -> prioritised command bytes, 2-cycle request latency.
// Command held valid until encoder ready; MIN_GAP idle cycles are enforced after each accepted command.
module ttc_chanb_broadcast_tx #(
    parameter int MIN_GAP   = 44,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_enable_i,
    input  logic                       req_fill_type_i,
    input  logic [1:0]                 fill_type_i,
    input  logic                       req_ts_reset_i,
    input  logic                       req_evt_reset_i,
    ttc_chanb_broadcast_tx_if.master   tx_bus,
    output logic                       busy_o,
    output logic [2:0]                 pending_o,
    output logic [CNT_WIDTH-1:0]       sent_count_o,
    output logic [CNT_WIDTH-1:0]       coalesced_count_o,
    output logic [CNT_WIDTH-1:0]       rejected_count_o
);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [7:0]           data_q, data_d;
    logic [2:0]           pend_q, pend_d;
    logic [2:0]           set_c, clr_c;
    logic [1:0]           ft_q, ft_d;
    logic [1:0]           n_coal;
    logic                 fill_ok;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [CNT_WIDTH-1:0] coal_q, coal_d;
    logic [CNT_WIDTH-1:0] rej_q, rej_d;
    logic [CNT_WIDTH:0]   coal_sum;

    assign fill_ok = req_fill_type_i && (fill_type_i != 2'b00);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        data_d  = data_q;
        sent_d  = sent_q;
        clr_c   = 3'b000;
        set_c   = {req_evt_reset_i, req_ts_reset_i, fill_ok};
        n_coal  = {1'b0, set_c[0] & pend_q[0]} + {1'b0, set_c[1] & pend_q[1]}
                + {1'b0, set_c[2] & pend_q[2]};

        case (state_q)
            IDLE: begin
                if (tx_enable_i && (|pend_q)) begin
                    state_d = SEND;
                    // a pending event-count reset rides along in bit 0 of whatever is loaded
                    if (pend_q[1]) begin
                        data_d = {7'b0010100, pend_q[2]};
                        clr_c  = 3'b110;
                    end else if (pend_q[0]) begin
                        data_d = {1'b1, ft_q, 3'b000, 1'b0, pend_q[2]};
                        clr_c  = 3'b101;
                    end else begin
                        data_d = 8'h01;
                        clr_c  = 3'b100;
                    end
                end
            end
            SEND: begin
                if (tx_bus.brcst_ready) begin
                    sent_d = sent_q + 1'b1;
                    if (MIN_GAP > 0) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(MIN_GAP - 1)) state_d = IDLE;
                else                           gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // a set in the same cycle as the load-clear survives, giving a follow-up command
        pend_d   = (pend_q & ~clr_c) | set_c;
        ft_d     = fill_ok ? fill_type_i : ft_q;
        coal_sum = {1'b0, coal_q} + {{(CNT_WIDTH-1){1'b0}}, n_coal};
        coal_d   = coal_sum[CNT_WIDTH] ? '1 : coal_sum[CNT_WIDTH-1:0];
        rej_d    = rej_q;
        if (req_fill_type_i && (fill_type_i == 2'b00) && (rej_q != '1))
            rej_d = rej_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
            data_q  <= 8'h00;
            pend_q  <= 3'b000;
            ft_q    <= 2'b01;
            sent_q  <= '0;
            coal_q  <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            ft_q    <= ft_d;
            sent_q  <= sent_d;
            coal_q  <= coal_d;
            rej_q   <= rej_d;
        end
    end

    assign tx_bus.brcst_data  = data_q;
    assign tx_bus.brcst_valid = (state_q == SEND);
    assign busy_o             = (state_q != IDLE);
    assign pending_o          = pend_q;
    assign sent_count_o       = sent_q;
    assign coalesced_count_o  = coal_q;
    assign rejected_count_o   = rej_q;
endmodule
